// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter: RAM handshake states,
// arbiter FSM states and the word type used on every data path.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/arb_timeout.sv
// Grant watchdog: counts cycles spent in a grant and flags when TIMEOUT is reached.
module arb_timeout #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store,
// returning one-cycle ihit/dhit pulses with a forced completion on RAM error or timeout.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        merr,
    output logic        busy
);

    arb_state_t state, next_state;
    ramstate_t  rs;
    logic       grant, expired, finish, fault;
    logic       pick_d, pick_i;
    word_t      lat_addr, lat_data, iload_q, dload_q;
    logic       lat_wr, last_was_d, err;

    assign rs     = ramstate_t'(ramstate);
    assign grant  = (state == DGRANT) || (state == IGRANT);
    assign finish = grant && ((rs == ACCESS) || (rs == ERROR) || expired);
    // ACCESS wins over a coincident expiry: the RAM data is genuine.
    assign fault  = (rs != ACCESS);

    arb_timeout #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout (
        .CLK     (CLK),
        .nRST    (nRST),
        .clr     (!grant),
        .en      (grant),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A pending fetch goes ahead of data whenever data held the previous grant.
    always_comb begin
        next_state = state;
        pick_d     = 1'b0;
        pick_i     = 1'b0;
        case (state)
            IDLE: begin
                if (iREN && last_was_d) begin
                    pick_i = 1'b1;
                end else if (dWEN || dREN) begin
                    pick_d = 1'b1;
                end else if (iREN) begin
                    pick_i = 1'b1;
                end
                if (pick_d) begin
                    next_state = DGRANT;
                end else if (pick_i) begin
                    next_state = IGRANT;
                end
            end
            DGRANT, IGRANT: begin
                if (finish) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_wr     <= 1'b0;
            last_was_d <= 1'b0;
            err        <= 1'b0;
            iload_q    <= '0;
            dload_q    <= '0;
        end else begin
            if (pick_d) begin
                lat_addr <= daddr;
                lat_data <= dstore;
                lat_wr   <= dWEN;
            end else if (pick_i) begin
                lat_addr <= iaddr;
                lat_wr   <= 1'b0;
            end
            if (finish) begin
                err        <= fault;
                last_was_d <= (state == DGRANT);
                if (state == DGRANT) begin
                    dload_q <= fault ? BAD_WORD : ramload;
                end else begin
                    iload_q <= fault ? BAD_WORD : ramload;
                end
            end
        end
    end

    // last_was_d is updated on grant exit, so in DONE it names the finished requester.
    always_comb begin
        ramREN   = (state == IGRANT) || ((state == DGRANT) && !lat_wr);
        ramWEN   = (state == DGRANT) && lat_wr;
        ramaddr  = grant ? lat_addr : '0;
        ramstore = ((state == DGRANT) && lat_wr) ? lat_data : '0;
        ihit     = (state == DONE) && !last_was_d;
        dhit     = (state == DONE) && last_was_d;
        merr     = (state == DONE) && err;
        busy     = (state != IDLE);
        iload    = iload_q;
        dload    = dload_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): fetch, priority, write precedence,
// fairness, timeout, RAM error and asynchronous reset during a grant.
module tb_mem_arbiter;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, merr, busy;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .ihit     (ihit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dhit     (dhit),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .merr     (merr),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = R_FREE;
        #1 nRST = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_hits", {ihit, dhit, merr}, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_iload", iload, 0);
        #9 nRST = 1'b1;
        tick();

        // fetch with two BUSY cycles
        iREN = 1; iaddr = 32'h40; ramstate = R_BUSY;
        tick();
        chk("f_ramREN", ramREN, 1);
        chk("f_ramaddr", ramaddr, 32'h40);
        chk("f_busy", busy, 1);
        chk("f_nohit", ihit, 0);
        tick();
        chk("f_wait", {ihit, ramREN}, 2'b01);
        ramstate = R_ACCESS; ramload = 32'h8C220004;
        tick();
        chk("f_ihit", ihit, 1);
        chk("f_iload", iload, 32'h8C220004);
        chk("f_strobe_off", ramREN, 0);
        chk("f_busy_done", busy, 1);
        iREN = 0; ramstate = R_FREE;
        tick();
        chk("f_ihit_once", ihit, 0);
        chk("f_busy_fall", busy, 0);
        chk("f_iload_hold", iload, 32'h8C220004);

        // simultaneous requests: data first
        dREN = 1; daddr = 32'h100; iREN = 1; iaddr = 32'h44;
        ramstate = R_ACCESS; ramload = 32'h11112222;
        tick();
        chk("s_dgrant_addr", ramaddr, 32'h100);
        chk("s_dgrant_strb", {ramREN, ramWEN}, 2'b10);
        tick();
        chk("s_dhit", {dhit, ihit}, 2'b10);
        chk("s_dload", dload, 32'h11112222);
        chk("s_done_strb", {ramREN, ramWEN}, 2'b00);
        dREN = 0;
        tick();
        chk("s_turnaround", {ramREN, ihit, dhit}, 0);
        ramload = 32'h33334444;
        tick();
        chk("s_igrant_addr", ramaddr, 32'h44);
        chk("s_igrant_strb", {ramREN, ramWEN}, 2'b10);
        tick();
        chk("s_ihit", {dhit, ihit}, 2'b01);
        chk("s_iload", iload, 32'h33334444);
        iREN = 0;
        tick();

        // write wins over read; live inputs ignored mid-grant
        dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramstate = R_BUSY;
        tick();
        chk("w_strb", {ramREN, ramWEN}, 2'b01);
        chk("w_store", ramstore, 32'hDEADBEEF);
        chk("w_addr", ramaddr, 32'h200);
        daddr = 32'h300; dstore = 32'h0;
        tick();
        chk("w_latched_addr", ramaddr, 32'h200);
        chk("w_latched_store", ramstore, 32'hDEADBEEF);
        ramstate = R_ACCESS;
        tick();
        chk("w_dhit", {dhit, merr}, 2'b10);
        dWEN = 0; dREN = 0;
        tick();

        // fairness: data held last, so fetch goes first, then alternate
        dREN = 1; daddr = 32'h500; iREN = 1; iaddr = 32'h600; ramstate = R_ACCESS;
        tick();
        chk("fa_i1", ramaddr, 32'h600);
        tick();
        chk("fa_ihit1", {ihit, dhit}, 2'b10);
        tick();
        chk("fa_idle1", ramREN, 0);
        tick();
        chk("fa_d1", ramaddr, 32'h500);
        tick();
        chk("fa_dhit1", {ihit, dhit}, 2'b01);
        tick();
        tick();
        chk("fa_i2", ramaddr, 32'h600);
        tick();
        chk("fa_ihit2", {ihit, dhit}, 2'b10);
        iREN = 0; dREN = 0;
        tick();

        // timeout: BUSY forever, completion 5 cycles after grant
        dREN = 1; daddr = 32'h700; ramstate = R_BUSY; ramload = 32'h55555555;
        tick();
        chk("t_grant", ramREN, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t_wait", {dhit, merr, ramREN}, 3'b001);
        end
        tick();
        chk("t_dhit_merr", {dhit, merr}, 2'b11);
        chk("t_dload", dload, 32'hBAD1BAD1);
        dREN = 0; ramstate = R_FREE;
        tick();
        chk("t_merr_once", {dhit, merr}, 2'b00);

        // RAM error on a fetch
        iREN = 1; iaddr = 32'h80; ramstate = R_ERROR; ramload = 32'h77777777;
        tick();
        chk("e_grant", ramaddr, 32'h80);
        tick();
        chk("e_ihit_merr", {ihit, merr, dhit}, 3'b110);
        chk("e_iload", iload, 32'hBAD1BAD1);
        iREN = 0; ramstate = R_FREE;
        tick();

        // asynchronous reset during a data grant
        dREN = 1; daddr = 32'h800; ramstate = R_BUSY;
        tick();
        chk("r_grant", ramREN, 1);
        #2 nRST = 1'b0;
        #1;
        chk("r_strb_drop", {ramREN, ramWEN, busy}, 0);
        chk("r_addr_clear", ramaddr, 0);
        tick();
        chk("r_nohit", dhit, 0);
        nRST = 1'b1;
        tick();
        chk("r_regrant", {ramREN, ramWEN}, 2'b10);
        chk("r_regrant_addr", ramaddr, 32'h800);
        ramstate = R_ACCESS; ramload = 32'h12345678;
        tick();
        chk("r_dhit", {dhit, merr}, 2'b10);
        chk("r_dload", dload, 32'h12345678);
        dREN = 0; ramstate = R_FREE;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM arbiter that sits between the pipelined datapath and unified RAM. It serves instruction fetches (iREN) and data loads and stores (dREN/dWEN) one at a time. It returns one-cycle ihit/dhit pulses, which the hazard unit consumes to release pipeline stalls. It is the responder end of the request/hit protocol the hazard unit stalls on.

## Interface
Parameters:
- TIMEOUT, default 255: maximum cycles a granted access may wait for ramstate==ACCESS before being force-completed.
- CW, default $clog2(TIMEOUT+1): timeout counter width, derived.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction fetch request, level; held until ihit.
- iaddr  in  32  fetch word address.
- iload  out  32  fetched instruction; valid while ihit=1.
- ihit  out  1  one-cycle fetch completion pulse.
- dREN  in  1  data read request, level.
- dWEN  in  1  data write request, level; wins over dREN if both are high.
- daddr  in  32  data word address.
- dstore  in  32  write data.
- dload  out  32  read data; valid while dhit=1.
- dhit  out  1  one-cycle data completion pulse, for both read and write.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid when ramstate==ACCESS.
- ramstate  in  2  FREE / BUSY / ACCESS / ERROR.
- merr  out  1  one-cycle pulse, coincident with the hit, when an access ended on ERROR or timeout.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, DGRANT, IGRANT, DONE.
- IDLE:
  - If dWEN|dREN: latch daddr, dstore and the op (write if dWEN), go to DGRANT.
  - Else if iREN: latch iaddr, go to IGRANT.
  - Fairness: if the previous completed grant was data and iREN is pending, IGRANT is taken before another data grant. A 1-bit last_was_d register tracks this.
- DGRANT/IGRANT:
  - Drive ramaddr/ramstore/ramREN/ramWEN from the latched values only. Live inputs are ignored, so request withdrawal mid-grant has no effect.
  - The timeout counter increments each cycle.
  - Exit to DONE when ramstate==ACCESS, ramstate==ERROR, or counter==TIMEOUT.
  - On ACCESS, capture ramload into the load register. On ERROR or timeout, load the register with 32'hBAD1BAD1 and set the error flag.
- DONE:
  - Strobes are low.
  - The matching hit is 1. merr=1 if the error flag is set.
  - The load output is held.
  - Next state is always IDLE. This guarantees one turnaround cycle between accesses.
- ihit and dhit are never high together. merr is never high without a hit.
- Reset values (async): state=IDLE, all strobes 0, ihit=dhit=merr=busy=0, iload=dload=ramaddr=ramstore=0, counter=0, last_was_d=0.

## Timing
- Request seen in IDLE at edge N -> strobes high from cycle N+1.
- ramstate==ACCESS sampled at edge M -> hit high for cycle M+1 only.
- Minimum latency from request assertion to hit: 3 cycles (IDLE -> GRANT -> DONE with immediate ACCESS).
- Requesters must hold the request and its address/data until the hit. A request still high in the IDLE cycle after DONE starts a new access.
- Timeout: hit occurs TIMEOUT+1 cycles after entering GRANT if ACCESS never arrives.
- Reset asserted mid-grant: strobes drop asynchronously and no hit is issued. The pending request is re-served after reset releases if still asserted.

## Structure
- cpu_types_pkg holds:
  - word_t (32-bit).
  - ramstate_t enum {FREE, BUSY, ACCESS, ERROR}.
  - arb_state_t enum {IDLE, DGRANT, IGRANT, DONE}.
  - localparam BAD_WORD = 32'hBAD1BAD1.
- Port grouping lives in the existing interface style as mem_arbiter_if.vh.
- One sub-module: arb_timeout, a CW-bit counter with clear, enable and expired outputs.
- The FSM, latches and outputs stay in mem_arbiter.

## Test plan
- Fetch: iREN=1, iaddr=0x40; RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C220004 -> ihit pulses once, iload=0x8C220004, busy falls the cycle after.
- Simultaneous: dREN=1 (daddr=0x100) and iREN=1 on the same cycle -> data granted first, dhit, DONE, then IGRANT, ihit; no overlapping strobes.
- Write/read precedence: dWEN=dREN=1, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dhit pulse.
- Fairness: dREN held continuously with iREN pending -> grants alternate D, I, D; ihit occurs within 2 access slots.
- Timeout with TIMEOUT=4: ramstate stuck BUSY -> dhit and merr pulse together 5 cycles after grant, dload=0xBAD1BAD1.
- Reset mid-grant: drop nRST during DGRANT -> strobes 0 immediately, no dhit; after release with dREN still high, a fresh DGRANT starts.
